alu_resp_rx: RTL and testbench

//  Serial response receiver for mtm_Alu: deserialises the sout line back into a

---
 rtl/alu_resp_rx_if.sv | 25 ++
 rtl/alu_resp_rx.sv | 203 ++++++++++++++++++++
 tb/tb_alu_resp_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_resp_rx_if.sv
// Serial response bus of the mtm_Alu receiver: the sout line in, decoded response out.
// The slave modport is the receiver side, the master modport is the line driver/observer.
interface alu_resp_rx_if;
  logic        sout;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_c;
  logic [3:0]  resp_flags;
  logic        resp_crc_ok;
  logic [2:0]  resp_err_flags;
  logic        resp_err_ok;
  logic        proto_err;

  modport slave (
    input  sout,
    output resp_valid, resp_err, resp_c, resp_flags, resp_crc_ok,
    output resp_err_flags, resp_err_ok, proto_err
  );

  modport master (
    output sout,
    input  resp_valid, resp_err, resp_c, resp_flags, resp_crc_ok,
    input  resp_err_flags, resp_err_ok, proto_err
  );
endinterface

// File: rtl/alu_resp_rx.sv
// Deserialises mtm_Alu sout frames into a data response (C, flags, CRC check)
// or an error response, flagging framing/sequence violations on proto_err.
module alu_resp_rx #(
  parameter int GAP_MAX = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_resp_rx_if.slave rx_bus
);

  localparam int GW = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TYPE,
    S_DATA,
    S_STOP,
    S_RESYNC
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_bit_cnt;
  logic        r_type;
  logic [7:0]  r_shift;
  logic [2:0]  r_fcnt;
  logic [GW-1:0] r_gap;
  logic [2:0]  r_crc;
  logic [31:0] r_c;

  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_c;
  logic [3:0]  r_resp_flags;
  logic        r_resp_crc_ok;
  logic [2:0]  r_resp_err_flags;
  logic        r_resp_err_ok;
  logic        r_proto_err;

  logic        w_sout;
  logic        w_store_data;
  logic        w_resp_data;
  logic        w_resp_err;
  logic        w_stop_proto;
  logic        w_gap_expire;
  logic [4:0]  w_ctl_bits;
  logic [2:0]  w_crc_chain [0:5];

  function automatic logic [2:0] crc3_step(input logic [2:0] c, input logic d);
    logic fb;
    fb = d ^ c[2];
    return {c[1], c[0] ^ fb, fb};
  endfunction

  assign w_sout = rx_bus.sout;

  // Finish the CRC over the zero separator bit and the four flag bits of the CTL frame
  assign w_ctl_bits     = {1'b0, r_shift[6:3]};
  assign w_crc_chain[0] = r_crc;
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_crc_tail
      assign w_crc_chain[gi+1] = crc3_step(w_crc_chain[gi], w_ctl_bits[4-gi]);
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_store_data = 1'b0;
    w_resp_data  = 1'b0;
    w_resp_err   = 1'b0;
    w_stop_proto = 1'b0;
    w_gap_expire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_sout) begin
          w_state_next = S_TYPE;
        end else if (r_fcnt != 3'd0 && r_gap == GW'(GAP_MAX)) begin
          w_gap_expire = 1'b1;
        end
      end
      S_TYPE: w_state_next = S_DATA;
      S_DATA: begin
        if (r_bit_cnt == 3'd0) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (!w_sout) begin
          w_stop_proto = 1'b1;
          w_state_next = S_RESYNC;
        end else begin
          w_state_next = S_IDLE;
          if (!r_type) begin
            if (r_fcnt < 3'd4) begin
              w_store_data = 1'b1;
            end else begin
              w_stop_proto = 1'b1;
            end
          end else if (r_fcnt == 3'd4 && !r_shift[7]) begin
            w_resp_data = 1'b1;
          end else if (r_fcnt == 3'd0 && r_shift[7]) begin
            w_resp_err = 1'b1;
          end else begin
            w_stop_proto = 1'b1;
          end
        end
      end
      S_RESYNC: begin
        if (w_sout) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_bit_cnt        <= 3'd0;
      r_type           <= 1'b0;
      r_shift          <= 8'd0;
      r_fcnt           <= 3'd0;
      r_gap            <= '0;
      r_crc            <= 3'd0;
      r_c              <= 32'd0;
      r_resp_valid     <= 1'b0;
      r_resp_err       <= 1'b0;
      r_resp_c         <= 32'd0;
      r_resp_flags     <= 4'd0;
      r_resp_crc_ok    <= 1'b0;
      r_resp_err_flags <= 3'd0;
      r_resp_err_ok    <= 1'b0;
      r_proto_err      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_resp_valid <= 1'b0;
      r_proto_err  <= 1'b0;

      // Idle-gap watchdog runs only while a response is partially received
      if (r_state == S_IDLE) begin
        if (!w_sout || w_gap_expire) begin
          r_gap <= '0;
        end else if (r_fcnt != 3'd0) begin
          r_gap <= r_gap + GW'(1);
        end
      end

      if (r_state == S_TYPE) begin
        r_type    <= w_sout;
        r_bit_cnt <= 3'd7;
        if (r_fcnt == 3'd0) begin
          r_crc <= 3'd0;
        end
      end

      if (r_state == S_DATA) begin
        r_shift   <= {r_shift[6:0], w_sout};
        r_bit_cnt <= r_bit_cnt - 3'd1;
        if (!r_type) begin
          r_crc <= crc3_step(r_crc, w_sout);
        end
      end

      if (w_store_data) begin
        r_c    <= {r_c[23:0], r_shift};
        r_fcnt <= r_fcnt + 3'd1;
      end

      if (w_resp_data) begin
        r_resp_valid  <= 1'b1;
        r_resp_err    <= 1'b0;
        r_resp_c      <= r_c;
        r_resp_flags  <= r_shift[6:3];
        r_resp_crc_ok <= (w_crc_chain[5] == r_shift[2:0]);
        r_fcnt        <= 3'd0;
      end

      if (w_resp_err) begin
        r_resp_valid     <= 1'b1;
        r_resp_err       <= 1'b1;
        r_resp_err_flags <= r_shift[6:4];
        r_resp_err_ok    <= !(^r_shift) && (r_shift[6:4] == r_shift[3:1]);
        r_fcnt           <= 3'd0;
      end

      if (w_stop_proto || w_gap_expire) begin
        r_proto_err <= 1'b1;
        r_fcnt      <= 3'd0;
      end
    end
  end

  assign rx_bus.resp_valid     = r_resp_valid;
  assign rx_bus.resp_err       = r_resp_err;
  assign rx_bus.resp_c         = r_resp_c;
  assign rx_bus.resp_flags     = r_resp_flags;
  assign rx_bus.resp_crc_ok    = r_resp_crc_ok;
  assign rx_bus.resp_err_flags = r_resp_err_flags;
  assign rx_bus.resp_err_ok    = r_resp_err_ok;
  assign rx_bus.proto_err      = r_proto_err;

endmodule

// File: tb/tb_alu_resp_rx.sv
// Scoreboard bench for alu_resp_rx: directed framing cases plus random back-to-back
// responses; expectations come from a polynomial-division CRC model.
module tb_alu_resp_rx;

  localparam int GAP_MAX = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_resp_rx_if bus ();

  alu_resp_rx #(.GAP_MAX(GAP_MAX)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_bus (bus)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] c;
    logic [3:0]  flags;
    logic        crc_ok;
    logic [2:0]  eflags;
    logic        eok;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   proto_seen = 0;
  int   proto_exp  = 0;
  int   valid_seen = 0;
  int   valid_exp  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] crc_model(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  // Monitor: pop one expectation per resp_valid pulse
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (bus.resp_valid && bus.proto_err) check("pulse_excl", 32'd1, 32'd0);
      if (bus.proto_err) begin
        proto_seen++;
        $display("[TB] proto_err pulse #%0d", proto_seen);
      end
      if (bus.resp_valid) begin
        valid_seen++;
        $display("[TB] resp err=%0b c=%08h flags=%04b crc_ok=%0b eflags=%03b eok=%0b",
                 bus.resp_err, bus.resp_c, bus.resp_flags, bus.resp_crc_ok,
                 bus.resp_err_flags, bus.resp_err_ok);
        if (sb_q.size() == 0) begin
          check("unexp_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          if (!e.err) begin
            check("resp_c", bus.resp_c, e.c);
            check("resp_flags", {28'd0, bus.resp_flags}, {28'd0, e.flags});
            check("resp_crc_ok", {31'd0, bus.resp_crc_ok}, {31'd0, e.crc_ok});
          end else begin
            check("resp_err_flags", {29'd0, bus.resp_err_flags}, {29'd0, e.eflags});
            check("resp_err_ok", {31'd0, bus.resp_err_ok}, {31'd0, e.eok});
          end
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    bus.sout = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop = 1'b1);
    drive_bit(1'b0);
    drive_bit(t);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic push_data(input logic [31:0] c, input logic [3:0] f, input logic ok);
    exp_t e;
    e = '0;
    e.c = c; e.flags = f; e.crc_ok = ok;
    sb_q.push_back(e);
    valid_exp++;
  endtask

  task automatic push_err(input logic [2:0] ef, input logic ok);
    exp_t e;
    e = '0;
    e.err = 1'b1; e.eflags = ef; e.eok = ok;
    sb_q.push_back(e);
    valid_exp++;
  endtask

  task automatic send_data_resp(input logic [31:0] c, input logic [3:0] f,
                                input logic bad_crc, input int gap);
    logic [2:0] crc;
    crc = crc_model({c, 1'b0, f});
    if (bad_crc) crc = crc ^ 3'b001;
    push_data(c, f, !bad_crc);
    for (int k = 3; k >= 0; k--) begin
      send_frame(1'b0, c[k*8 +: 8]);
      idle(gap);
    end
    send_frame(1'b1, {1'b0, f, crc});
  endtask

  task automatic send_err_resp(input logic [2:0] ef, input logic bad_par, input logic bad_copy);
    logic [2:0] ef2;
    logic [6:0] body;
    logic       par;
    ef2  = bad_copy ? (ef ^ 3'b010) : ef;
    body = {1'b1, ef, ef2};
    par  = ^body;
    if (bad_par) par = ~par;
    push_err(ef, !bad_par && !bad_copy);
    send_frame(1'b1, {body, par});
  endtask

  task automatic settle(input string tag);
    idle(4);
    check({tag, "_proto"}, proto_seen, proto_exp);
    check({tag, "_valid"}, valid_seen, valid_exp);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sout = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_proto", {31'd0, bus.proto_err}, 32'd0);
    check("rst_c", bus.resp_c, 32'd0);
    check("rst_flags", {28'd0, bus.resp_flags}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Zero result with correct and with corrupted CRC
    push_data(32'd0, 4'b0010, 1'b1);
    for (int k = 0; k < 4; k++) send_frame(1'b0, 8'h00);
    send_frame(1'b1, 8'h16);
    push_data(32'd0, 4'b0010, 1'b0);
    for (int k = 0; k < 4; k++) send_frame(1'b0, 8'h00);
    send_frame(1'b1, 8'h17);

    // Error responses, good and bad parity
    push_err(3'b001, 1'b1);
    send_frame(1'b1, 8'h93);
    push_err(3'b001, 1'b0);
    send_frame(1'b1, 8'h92);
    settle("t123");

    // Broken stop bit on the 2nd DATA frame, then a good response
    send_frame(1'b0, 8'hAA);
    send_frame(1'b0, 8'hBB, 1'b0);
    proto_exp++;
    idle(3);
    send_data_resp(32'h1234_5678, 4'b1001, 1'b0, 0);
    settle("t4");

    // Too few and too many DATA frames
    for (int k = 0; k < 3; k++) send_frame(1'b0, 8'h11);
    send_frame(1'b1, 8'h16);
    proto_exp++;
    settle("t5a");
    for (int k = 0; k < 5; k++) send_frame(1'b0, 8'h22);
    proto_exp++;
    settle("t5b");

    // Gap limit: GAP_MAX+1 idle cycles aborts, GAP_MAX is still accepted
    send_frame(1'b0, 8'h33);
    send_frame(1'b0, 8'h44);
    idle(GAP_MAX + 1);
    proto_exp++;
    settle("t6gap");
    send_data_resp(32'hDEAD_BEEF, 4'b0101, 1'b0, GAP_MAX);
    settle("t6edge");

    // Reset in the middle of a frame
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_c", bus.resp_c, 32'd0);
    check("mid_rst_flags", {28'd0, bus.resp_flags}, 32'd0);
    check("mid_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("mid_rst_proto", {31'd0, bus.proto_err}, 32'd0);
    @(negedge clk);
    bus.sout = 1'b1;
    rst_n    = 1'b1;
    idle(2);
    send_data_resp(32'hCAFE_0001, 4'b1100, 1'b0, 1);
    settle("t6rst");

    // Random responses, mostly back-to-back
    for (int n = 0; n < 24; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        send_err_resp(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0));
      end else begin
        send_data_resp($urandom, 4'($urandom_range(0, 15)), kind == 2,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, GAP_MAX) : 0);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 30));
    end
    idle(10);
    check("rand_proto", proto_seen, proto_exp);
    check("rand_valid", valid_seen, valid_exp);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
